// File: rtl/adder32_rr_scheduler.sv
// One shared 32-bit carry-lookahead adder time-multiplexed between NUM_REQ
// requesters by a round-robin arbiter, with a one-entry tagged result register.

module carry_lookahead_adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [32:0] sum
);

  logic [7:0] grp_g;
  logic [7:0] grp_p;
  logic [8:0] grp_c;
  logic       la_term;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_grp
      logic [3:0] g;
      logic [3:0] p;
      logic [3:0] c;

      assign g = a[4*gi +: 4] & b[4*gi +: 4];
      assign p = a[4*gi +: 4] ^ b[4*gi +: 4];

      assign c[0] = grp_c[gi];
      assign c[1] = g[0] | (p[0] & c[0]);
      assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & c[0]);

      assign grp_g[gi] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                       | (p[3] & p[2] & p[1] & g[0]);
      assign grp_p[gi] = &p;

      assign sum[4*gi +: 4] = p ^ c;
    end
  endgenerate

  // Second lookahead level: each group carry straight from group generate/propagate.
  always_comb begin
    grp_c   = '0;
    la_term = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      for (int j = 0; j < k; j++) begin
        la_term = grp_g[j];
        for (int m = j + 1; m < k; m++) begin
          la_term = la_term & grp_p[m];
        end
        grp_c[k] = grp_c[k] | la_term;
      end
    end
  end

  assign sum[32] = grp_c[8];

endmodule

module adder32_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*32-1:0] add1_i,
  input  logic [NUM_REQ*32-1:0] add2_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [32:0]           result_o,
  output logic [ID_W-1:0]       rsp_id_o,
  output logic [15:0]           ops_cnt_o
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state_reg;
  logic [ID_W-1:0] ptr_reg;
  logic [ID_W-1:0] ptr_next;
  logic [32:0]     result_reg;
  logic [ID_W-1:0] rsp_id_reg;
  logic [15:0]     ops_cnt_reg;

  logic [ID_W-1:0] grant_idx;
  logic            grant_found;
  logic            can_accept;
  logic            grant;
  int              cand;
  logic [31:0]     op_a;
  logic [31:0]     op_b;
  logic [32:0]     sum;

  // Rotating priority search starting at ptr_reg.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr_reg) + i) % NUM_REQ;
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  assign can_accept = (state_reg == EMPTY) || rsp_ready_i;
  // rst_ni gates the grant so no requester sees ready while reset is asserted.
  assign grant      = rst_ni && grant_found && can_accept;
  assign ptr_next   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  always_comb begin
    req_ready_o = '0;
    if (grant) begin
      req_ready_o = NUM_REQ'(1) << grant_idx;
    end
  end

  assign op_a = add1_i[32*grant_idx +: 32];
  assign op_b = add2_i[32*grant_idx +: 32];

  carry_lookahead_adder32 u_adder (
    .a   (op_a),
    .b   (op_b),
    .sum (sum)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= EMPTY;
      ptr_reg     <= '0;
      result_reg  <= '0;
      rsp_id_reg  <= '0;
      ops_cnt_reg <= '0;
    end else begin
      if (state_reg == FULL && rsp_ready_i) begin
        ops_cnt_reg <= ops_cnt_reg + 16'd1;
      end
      if (grant) begin
        state_reg  <= FULL;
        result_reg <= sum;
        rsp_id_reg <= grant_idx;
        ptr_reg    <= ptr_next;
      end else if (rsp_ready_i) begin
        state_reg  <= EMPTY;
      end
    end
  end

  assign rsp_valid_o = (state_reg == FULL);
  assign result_o    = result_reg;
  assign rsp_id_o    = rsp_id_reg;
  assign ops_cnt_o   = ops_cnt_reg;

endmodule

// File: tb/tb_adder32_rr_scheduler.sv
// Directed bench for adder32_rr_scheduler: reset, sums, carry-out, round-robin
// order, back-pressure, counter wrap and asynchronous mid-run reset.

module tb_adder32_rr_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] add1 = '0;
  logic [NUM_REQ*32-1:0] add2 = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [32:0]           result;
  logic [ID_W-1:0]       rsp_id;
  logic [15:0]           ops_cnt;

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [31:0] rr_a [4] = '{32'h00000001, 32'h80000000, 32'h12345678, 32'hFFFF0000};
  logic [31:0] rr_b [4] = '{32'h00000002, 32'h80000000, 32'h11111111, 32'h00010000};
  logic [32:0] rr_s [4] = '{33'h000000003, 33'h100000000, 33'h023456789, 33'h100000000};

  adder32_rr_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .add1_i      (add1),
    .add2_i      (add2),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .result_o    (result),
    .rsp_id_o    (rsp_id),
    .ops_cnt_o   (ops_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int k, input logic [31:0] a, input logic [31:0] b);
    add1[32*k +: 32] = a;
    add2[32*k +: 32] = b;
  endtask

  task automatic load_rr_ops();
    for (int k = 0; k < NUM_REQ; k++) set_op(k, rr_a[k], rr_b[k]);
  endtask

  initial begin
    // Reset held with every requester asking.
    load_rr_ops();
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(rsp_valid), 64'h0);
    check("rst_result", 64'(result), 64'h0);
    check("rst_id", 64'(rsp_id), 64'h0);
    check("rst_cnt", 64'(ops_cnt), 64'h0);
    check("rst_ready", 64'(req_ready), 64'h0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("first_ready", 64'(req_ready), 64'h1);
    tick();
    check("first_valid", 64'(rsp_valid), 64'h1);
    check("first_id", 64'(rsp_id), 64'h0);
    check("first_result", 64'(result), 64'h3);
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    check("first_drain_valid", 64'(rsp_valid), 64'h0);
    check("first_drain_cnt", 64'(ops_cnt), 64'h1);

    // Single requester 1 (pointer now at 1).
    set_op(1, 32'h29AF2430, 32'h7A1B9ABC);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1;
    check("single_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    check("single_result", 64'(result), 64'h0A3CABEEC);
    check("single_id", 64'(rsp_id), 64'h1);
    check("single_valid", 64'(rsp_valid), 64'h1);
    rsp_ready = 1'b1;
    tick();
    check("single_drain_valid", 64'(rsp_valid), 64'h0);
    check("single_drain_cnt", 64'(ops_cnt), 64'h2);

    // Carry-out cases, second one loaded on the same edge that drains the first.
    set_op(2, 32'hFFFFFFFF, 32'h00000001);
    set_op(3, 32'h55555555, 32'hAAAAAAAA);
    req_valid = 4'b0100;
    tick();
    check("carry_result", 64'(result), 64'h100000000);
    check("carry_id", 64'(rsp_id), 64'h2);
    req_valid = 4'b1000;
    tick();
    check("nocarry_result", 64'(result), 64'h0FFFFFFFF);
    check("nocarry_id", 64'(rsp_id), 64'h3);
    check("nocarry_cnt", 64'(ops_cnt), 64'h3);
    req_valid = '0;
    tick();
    check("carry_drain_valid", 64'(rsp_valid), 64'h0);
    check("carry_drain_cnt", 64'(ops_cnt), 64'h4);

    // Round robin with all four requesters, pointer back at 0.
    load_rr_ops();
    req_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("rr4_ready_%0d", c), 64'(req_ready), 64'(4'b0001 << (c % 4)));
      tick();
      check($sformatf("rr4_id_%0d", c), 64'(rsp_id), 64'(c % 4));
      check($sformatf("rr4_result_%0d", c), 64'(result), 64'(rr_s[c % 4]));
    end
    check("rr4_cnt", 64'(ops_cnt), 64'd11);

    req_valid = 4'b0101;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("rr2_ready_%0d", c), 64'(req_ready), 64'((c % 2 == 0) ? 4'b0001 : 4'b0100));
      tick();
      check($sformatf("rr2_id_%0d", c), 64'(rsp_id), 64'((c % 2 == 0) ? 0 : 2));
    end
    check("rr2_cnt", 64'(ops_cnt), 64'd15);

    // Back-pressure: FULL with requester 2's result, pointer at 3.
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("bp_ready_%0d", c), 64'(req_ready), 64'h0);
      tick();
      check($sformatf("bp_id_%0d", c), 64'(rsp_id), 64'h2);
      check($sformatf("bp_result_%0d", c), 64'(result), 64'(rr_s[2]));
      check($sformatf("bp_valid_%0d", c), 64'(rsp_valid), 64'h1);
    end
    check("bp_cnt", 64'(ops_cnt), 64'd15);
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(req_ready), 64'h8);
    tick();
    check("bp_release_id", 64'(rsp_id), 64'h3);
    check("bp_release_result", 64'(result), 64'(rr_s[3]));
    check("bp_release_cnt", 64'(ops_cnt), 64'd16);

    // Stream until the counter reaches 0xFFFF, then one more handshake wraps it.
    repeat (65535 - 16) @(posedge clk);
    #1;
    check("wrap_pre_cnt", 64'(ops_cnt), 64'hFFFF);
    check("wrap_pre_valid", 64'(rsp_valid), 64'h1);
    tick();
    check("wrap_cnt", 64'(ops_cnt), 64'h0);

    // Asynchronous reset while FULL.
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(rsp_valid), 64'h0);
    check("midrst_result", 64'(result), 64'h0);
    check("midrst_cnt", 64'(ops_cnt), 64'h0);
    check("midrst_ready", 64'(req_ready), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("postrst_ready", 64'(req_ready), 64'h1);
    tick();
    check("postrst_id", 64'(rsp_id), 64'h0);
    check("postrst_result", 64'(result), 64'(rr_s[0]));
    check("postrst_cnt", 64'(ops_cnt), 64'h0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
